gol_tick_gen: RTL and testbench
===============================

# gol_tick_gen

Generation-tick generator for the Game of Life array. Sits directly upstream of the cell grid: it turns the speed switches, run switch and step key into single-cycle `tick` pulses that advance every cell by one generation. With frame alignment compiled in, ticks land on VGA vertical sync so the displayed frame never tears mid-generation. Runs on the 50 MHz board clock.

## Interface
- `CLK_HZ`, 50000000, base tick period in clock cycles at speed 0
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required to accept a step-key level change (10 ms)
- `GEN_W`, 16, width of the generation counter
- `Clk`  in  1  board clock (MAX10_CLK1_50)
- `Reset_n`  in  1  reset; one clock, reset is synchronous and active-low
- `speed`  in  4  period shift: period = CLK_HZ >> speed
- `run_en`  in  1  1 = free-running ticks, 0 = paused (step only)
- `step_n`  in  1  raw step key, active-low, asynchronous, bouncy
- `vs_in`  in  1  VGA vsync, active-low, asynchronous to `Clk`
- `tick`  out  1  one-cycle generation-advance pulse
- `gen_count`  out  GEN_W  generations issued since reset
- `overrun`  out  1  sticky: a tick request arrived while one was already pending

## Operation
- Period counter `pcnt` (32 bit):
  - Held at 0 while `run_en`=0.
  - Otherwise increments each cycle. When `pcnt >= (CLK_HZ >> speed) - 1` it returns to 0 and raises a run request.
  - The `>=` compare makes a mid-count speed increase terminate the current period on the next cycle.
- Step path:
  - `step_n` passes through a 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free cycle resets the counter.
  - A debounced 1→0 transition raises a step request. Steps are accepted regardless of `run_en`.
- `vs_in` passes through a 2-FF synchronizer. A falling edge of the synchronized signal is a frame event.
- FSM states: IDLE, PEND, FIRE.
  - IDLE → PEND on any request.
  - PEND → FIRE on a frame event. Without the macro, PEND → FIRE unconditionally next cycle.
  - FIRE → IDLE. Or FIRE → PEND if a request arrives in FIRE.
- `tick` = 1 only in FIRE. `gen_count` increments in FIRE and wraps modulo 2^GEN_W.
- Coalescing: a request arriving in PEND is merged into the pending tick (one tick issued) and sets `overrun`. Simultaneous run and step requests in the same cycle count as one request, with no overrun.
- `overrun` clears only on reset.

## Timing
- All outputs are registered. Reset values: `tick`=0, `gen_count`=0, `overrun`=0. Internal reset values: FSM=IDLE, `pcnt`=0, debounced step level=1, synchronizers=1.
- Reset is sampled on `Clk`. Asserting it mid-PEND or mid-FIRE drops the pending tick. No tick is issued in the cycle after reset deasserts.
- Run latency: a request on the cycle `pcnt` wraps, PEND the next cycle. `tick` follows one cycle later (no macro) or one cycle after the frame event (macro).
- Step latency: the raw `step_n` fall is accepted after 2 sync cycles + DEBOUNCE_CYCLES, then the request cycle, then PEND.
- Frame event: detected 3 cycles after the raw `vs_in` fall (2 sync + edge register).
- Minimum tick spacing: 2 cycles (FIRE→PEND→FIRE without the macro).

## Configuration
- `GOL_TICK_VSYNC_ALIGN_EN` defined: PEND waits for a frame event. `vs_in` synchronizer and edge detector are present. At most one tick per frame.
- Undefined: `vs_in` is ignored (synchronizer removed). PEND always advances to FIRE the next cycle.

## Test plan
- CLK_HZ=64, speed=2, run_en=1, no macro, after reset → `tick` every 16 cycles; `gen_count` reads 4 after 4 ticks; `overrun`=0.
- speed changed 0→4 while `pcnt`=40 (CLK_HZ=64) → wrap next cycle. Subsequent ticks every 4 cycles.
- run_en=0, DEBOUNCE_CYCLES=4: `step_n` bounces 1-0-1-0 at 1-cycle intervals then held 0 → exactly one `tick`, 2+4+2 cycles after the final fall (no macro). Release and re-press → second tick.
- Macro on, run_en=1, period 8, `vs_in` pulsed every 40 cycles → one `tick` per vsync, 3 cycles after each `vs_in` fall; `overrun`=1 after the second period.
- GEN_W=4: 17 ticks → `gen_count`=1 (wrap).
- Reset_n=0 for 1 cycle during PEND → no `tick`; `gen_count`=0; `overrun`=0; normal ticking resumes one full period later.

Source files
------------

// File: rtl/gol_tick_gen.sv
// gol_tick_gen: turns speed/run switches and the step key into one-cycle
// generation ticks for the Life grid, optionally aligned to VGA vsync.
//
// Optional feature macro: GOL_TICK_VSYNC_ALIGN_EN
//   defined   -> a pending tick waits for a vsync falling edge (frame event)
//   undefined -> vs_in is ignored, a pending tick fires on the next cycle
//
// Ports:
//   Clk        board clock
//   Reset_n    synchronous active-low reset
//   speed      period shift, period = CLK_HZ >> speed
//   run_en     1 = free-running ticks, 0 = step key only
//   step_n     raw active-low step key (asynchronous, bouncy)
//   vs_in      raw active-low VGA vsync (asynchronous)
//   tick       one-cycle generation-advance pulse (registered)
//   gen_count  generations issued since reset, wraps (registered)
//   overrun    sticky, a request hit an already-pending tick (registered)
module gol_tick_gen #(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int GEN_W           = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [3:0]       speed,
  input  logic             run_en,
  input  logic             step_n,
  input  logic             vs_in,
  output logic             tick,
  output logic [GEN_W-1:0] gen_count,
  output logic             overrun
);

  localparam logic [31:0] CLK_HZ_U = 32'(CLK_HZ);
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    FIRE = 2'd2
  } state_t;

  // ---------------------------------------------------------------
  // Period counter / run request
  // ---------------------------------------------------------------
  logic [31:0] r_pcnt;
  logic [31:0] w_period;
  logic [31:0] w_limit;
  logic        w_run_req;

  assign w_period = CLK_HZ_U >> speed;
  // A shift that leaves a zero period means "request every cycle".
  assign w_limit  = (w_period == 32'd0) ? 32'd0 : (w_period - 32'd1);
  // >= rather than == so a speed increase mid-count ends the period at once.
  assign w_run_req = run_en && (r_pcnt >= w_limit);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_pcnt <= 32'd0;
    end else if (!run_en || w_run_req) begin
      r_pcnt <= 32'd0;
    end else begin
      r_pcnt <= r_pcnt + 32'd1;
    end
  end

  // ---------------------------------------------------------------
  // Step key: synchronizer, debounce, falling-edge request
  // ---------------------------------------------------------------
  logic            r_step_s1;
  logic            r_step_s2;
  logic            r_step_db;
  logic            r_step_db_d;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_step_req;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_step_s1   <= 1'b1;
      r_step_s2   <= 1'b1;
      r_step_db   <= 1'b1;
      r_step_db_d <= 1'b1;
      r_db_cnt    <= '0;
    end else begin
      r_step_s1   <= step_n;
      r_step_s2   <= r_step_s1;
      r_step_db_d <= r_step_db;
      // Count consecutive disagreeing cycles; any agreeing cycle restarts.
      if (r_step_s2 != r_step_db) begin
        if (r_db_cnt == DB_LAST) begin
          r_step_db <= r_step_s2;
          r_db_cnt  <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_step_req = r_step_db_d & ~r_step_db;

  // ---------------------------------------------------------------
  // Frame event
  // ---------------------------------------------------------------
  logic w_frame;

`ifdef GOL_TICK_VSYNC_ALIGN_EN
  logic r_vs_s1;
  logic r_vs_s2;
  logic r_vs_d;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_vs_s1 <= 1'b1;
      r_vs_s2 <= 1'b1;
      r_vs_d  <= 1'b1;
    end else begin
      r_vs_s1 <= vs_in;
      r_vs_s2 <= r_vs_s1;
      r_vs_d  <= r_vs_s2;
    end
  end

  assign w_frame = r_vs_d & ~r_vs_s2;
`else
  logic w_unused_vs;
  assign w_unused_vs = vs_in;
  assign w_frame     = 1'b1;
`endif

  // ---------------------------------------------------------------
  // Tick FSM
  // ---------------------------------------------------------------
  state_t r_state;
  state_t w_next;
  logic   w_req;
  logic   w_ovr_set;

  // Run and step in the same cycle are one request.
  assign w_req = w_run_req | w_step_req;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_ovr_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) w_next = PEND;
      end
      PEND: begin
        // A second request is folded into the pending tick.
        if (w_req)   w_ovr_set = 1'b1;
        if (w_frame) w_next    = FIRE;
      end
      FIRE: begin
        w_next = w_req ? PEND : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------
  logic             r_tick;
  logic [GEN_W-1:0] r_gen;
  logic             r_ovr;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_tick <= 1'b0;
      r_gen  <= '0;
      r_ovr  <= 1'b0;
    end else begin
      r_tick <= (w_next == FIRE);
      if (r_state == FIRE) r_gen <= r_gen + GEN_W'(1);
      if (w_ovr_set)       r_ovr <= 1'b1;
    end
  end

  assign tick      = r_tick;
  assign gen_count = r_gen;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_gol_tick_gen.sv
// Bench for gol_tick_gen with CLK_HZ=64, DEBOUNCE_CYCLES=4, GEN_W=4.
// The model is a schedule of cycles on which a tick must appear, derived
// from the period/debounce/sync rules; gen_count and overrun follow from it.
module tb_gol_tick_gen;

  localparam int GEN_W = 4;
  localparam int BIG   = 32'h7fff_ffff;

  logic             clk;
  logic             Reset_n;
  logic [3:0]       speed;
  logic             run_en;
  logic             step_n;
  logic             vs_in;
  logic             tick;
  logic [GEN_W-1:0] gen_count;
  logic             overrun;

  gol_tick_gen #(
    .CLK_HZ(64),
    .DEBOUNCE_CYCLES(4),
    .GEN_W(GEN_W)
  ) dut (
    .Clk(clk),
    .Reset_n(Reset_n),
    .speed(speed),
    .run_en(run_en),
    .step_n(step_n),
    .vs_in(vs_in),
    .tick(tick),
    .gen_count(gen_count),
    .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;     // number of rising edges so far
  bit rst_edge = 1'b1; // Reset_n was low at the latest rising edge

  bit exp_tick [int]; // cycles on which tick must be 1
  int ovr_from = BIG; // first cycle overrun must read 1
  int gen_exp  = 0;
  bit prev_t   = 1'b0;

  always @(posedge clk) begin
    cyc      = cyc + 1;
    rst_edge = !Reset_n;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the schedule model.
  always @(negedge clk) begin
    bit cur_t;
    bit ovr_e;
    if (cyc > 0) begin
      if (rst_edge) begin
        gen_exp  = 0;
        prev_t   = 1'b0;
        ovr_from = BIG;
      end else begin
        gen_exp = (gen_exp + int'(prev_t)) % (1 << GEN_W);
      end
      cur_t = !rst_edge && exp_tick.exists(cyc);
      ovr_e = !rst_edge && (cyc >= ovr_from);
      chk("tick", int'(tick), int'(cur_t));
      chk("gen_count", int'(gen_count), gen_exp);
      chk("overrun", int'(overrun), int'(ovr_e));
      prev_t = cur_t;
    end
  end

  // Return at 1 time unit after rising edge number n.
  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    @(negedge clk);
    chk(nm, act, exp);
  endtask

  task automatic add_ticks(input int first, input int period, input int n);
    for (int k = 0; k < n; k++) exp_tick[first + k * period] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    run_en  = 1'b0;
    speed   = 4'd2;
    step_n  = 1'b1;
    vs_in   = 1'b1;

    at_cyc(2);
    lit("rst_tick", int'(tick), 0);
    lit("rst_gen", int'(gen_count), 0);

`ifdef GOL_TICK_VSYNC_ALIGN_EN
    // Period 8: requests at edges 11,19,27,...; vsync falls at 30,70,110.
    at_cyc(3);
    Reset_n = 1'b1;
    run_en  = 1'b1;
    speed   = 4'd3;
    exp_tick[33]  = 1'b1;
    exp_tick[73]  = 1'b1;
    exp_tick[113] = 1'b1;
    at_cyc(4);
    ovr_from = 19;
    at_cyc(20);
    lit("vs_ovr", int'(overrun), 1);
    at_cyc(30);  vs_in = 1'b0;
    at_cyc(32);
    lit("vs_pre", int'(tick), 0);
    at_cyc(33);
    lit("vs_tick", int'(tick), 1);
    at_cyc(34);  vs_in = 1'b1;
    at_cyc(70);  vs_in = 1'b0;
    at_cyc(74);  vs_in = 1'b1;
    at_cyc(110); vs_in = 1'b0;
    at_cyc(114); vs_in = 1'b1;
    lit("vs_gen3", int'(gen_count), 3);
    at_cyc(120); run_en = 1'b0;
    at_cyc(140);
`else
    // Speed 2 -> period 16; counting starts at edge 4, first tick at 20.
    at_cyc(3);
    Reset_n = 1'b1;
    run_en  = 1'b1;
    add_ticks(20, 16, 4);
    at_cyc(19);
    lit("pre_first", int'(tick), 0);
    at_cyc(20);
    lit("first_tick", int'(tick), 1);
    at_cyc(30); vs_in = 1'b0;     // ignored in this build
    at_cyc(34); vs_in = 1'b1;
    at_cyc(69);
    lit("gen4", int'(gen_count), 4);
    lit("ovr0", int'(overrun), 0);
    at_cyc(70);
    run_en = 1'b0;
    speed  = 4'd0;

    // Speed 0 (period 64) from edge 81; at pcnt=40 switch to speed 4.
    at_cyc(80);
    run_en = 1'b1;
    add_ticks(122, 4, 5);
    at_cyc(120);
    speed = 4'd4;
    at_cyc(122);
    lit("speedup_wrap", int'(tick), 1);
    at_cyc(139);
    run_en = 1'b0;

    // Bouncing step key, final fall at 152 -> tick at 160.
    exp_tick[160] = 1'b1;
    at_cyc(150); step_n = 1'b0;
    at_cyc(151); step_n = 1'b1;
    at_cyc(152); step_n = 1'b0;
    at_cyc(159);
    lit("step_pre", int'(tick), 0);
    at_cyc(160);
    lit("step_tick", int'(tick), 1);
    at_cyc(170); step_n = 1'b1;
    exp_tick[193] = 1'b1;
    at_cyc(185); step_n = 1'b0;
    at_cyc(193);
    lit("step2_tick", int'(tick), 1);
    at_cyc(195); step_n = 1'b1;

    // Reset, then speed 6 (request every cycle): ticks every 2 cycles,
    // overrun from the first PEND, 17 ticks wrap gen_count to 1.
    at_cyc(200);
    Reset_n = 1'b0;
    at_cyc(202);
    Reset_n = 1'b1;
    run_en  = 1'b1;
    speed   = 4'd6;
    add_ticks(204, 2, 17);
    at_cyc(203);
    ovr_from = 204;
    at_cyc(205);
    lit("min_space", int'(tick), 0);
    at_cyc(236);
    run_en = 1'b0;
    at_cyc(237);
    lit("wrap_gen", int'(gen_count), 1);
    lit("coalesce_ovr", int'(overrun), 1);

    // Speed 2 from edge 251: request at 266 (PEND); reset hits edge 267.
    at_cyc(250);
    speed  = 4'd2;
    run_en = 1'b1;
    at_cyc(266);
    Reset_n = 1'b0;
    add_ticks(284, 16, 2);
    at_cyc(267);
    Reset_n = 1'b1;
    lit("rstpend_tick", int'(tick), 0);
    lit("rstpend_ovr", int'(overrun), 0);
    at_cyc(268);
    lit("rstpend_gen", int'(gen_count), 0);
    at_cyc(284);
    lit("resume_tick", int'(tick), 1);
    at_cyc(302);
    run_en = 1'b0;
    at_cyc(320);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
